// File: rtl/tx_ctrl_regfile_pkg.sv
// Shared definitions for the transmitter control register file:
// register addresses, CTRL/STATUS bit positions and the sequencer state type.
package tx_ctrl_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_SIZE   = 1;
  localparam int ADDR_BURST  = 2;
  localparam int ADDR_STATUS = 3;

  localparam int CTRL_GO_BIT    = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ABORT_BIT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } tx_ctrl_state_t;

endpackage

// File: rtl/tx_ctrl_regfile_if.sv
// Host register bus: addressed write port plus registered read port.
interface tx_ctrl_regfile_if #(
  parameter int DW = 8,
  parameter int AW = 4
) ();
  logic          Twrite;
  logic [AW-1:0] Taddr;
  logic [DW-1:0] Tdata;
  logic          Tread;
  logic [DW-1:0] rdata;
  logic          rvalid;

  modport master (output Twrite, Taddr, Tdata, Tread, input rdata, rvalid);
  modport slave  (input Twrite, Taddr, Tdata, Tread, output rdata, rvalid);
endinterface

// File: rtl/tx_ctrl_regfile.sv
// Transmitter control register file: shadow SIZE/BURST registers, a GO-started
// burst sequencer counting beats, sticky done/abort status and registered readback.
module tx_ctrl_regfile
  import tx_ctrl_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  tx_ctrl_regfile_if.slave bus,
  output logic [DW-1:0] size_out,
  output logic [DW-1:0] burst_out,
  output logic          tx_req,
  input  logic          byte_done,
  output logic          done_irq
);

  tx_ctrl_state_t state_q, state_d;

  logic [DW-1:0] size_sh_q, size_sh_d;
  logic [DW-1:0] burst_sh_q, burst_sh_d;
  logic [DW-1:0] size_q, size_d;
  logic [DW-1:0] burst_q, burst_d;
  logic [DW-1:0] remaining_q, remaining_d;
  logic          done_st_q, done_st_d;
  logic          abort_st_q, abort_st_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic          wr_ctrl_s, wr_size_s, wr_burst_s, wr_status_s;
  logic          go_s, abort_s, last_beat_s;
  logic [DW-1:0] status_s;

  // Address decode uses the full address so unmapped addresses never alias.
  assign wr_ctrl_s   = bus.Twrite && (bus.Taddr == AW'(ADDR_CTRL));
  assign wr_size_s   = bus.Twrite && (bus.Taddr == AW'(ADDR_SIZE));
  assign wr_burst_s  = bus.Twrite && (bus.Taddr == AW'(ADDR_BURST));
  assign wr_status_s = bus.Twrite && (bus.Taddr == AW'(ADDR_STATUS));
  assign go_s        = wr_ctrl_s && bus.Tdata[CTRL_GO_BIT];
  assign abort_s     = wr_ctrl_s && bus.Tdata[CTRL_ABORT_BIT];
  assign last_beat_s = byte_done && (remaining_q == DW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes priority over the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d = (burst_sh_q == '0) ? DONE : ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (abort_s) begin
          state_d = IDLE;
        end else if (last_beat_s) begin
          state_d = DONE;
        end else begin
          state_d = ACTIVE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer outputs derived from the registered state.
  always_comb begin
    tx_req   = 1'b0;
    done_irq = 1'b0;
    case (state_q)
      ACTIVE:  tx_req   = 1'b1;
      DONE:    done_irq = 1'b1;
      default: begin
        tx_req   = 1'b0;
        done_irq = 1'b0;
      end
    endcase
  end

  // Live status word as seen by readback.
  always_comb begin
    status_s                 = '0;
    status_s[STAT_BUSY_BIT]  = (state_q == ACTIVE);
    status_s[STAT_DONE_BIT]  = done_st_q;
    status_s[STAT_ABORT_BIT] = abort_st_q;
  end

  // Register next values: shadows, active copies, beat counter, stickies, readback.
  always_comb begin
    size_sh_d   = wr_size_s  ? bus.Tdata : size_sh_q;
    burst_sh_d  = wr_burst_s ? bus.Tdata : burst_sh_q;
    size_d      = size_q;
    burst_d     = burst_q;
    remaining_d = remaining_q;
    if ((state_q == IDLE) && go_s) begin
      size_d      = size_sh_q;
      burst_d     = burst_sh_q;
      remaining_d = burst_sh_q;
    end else if ((state_q == ACTIVE) && byte_done && (remaining_q != '0)) begin
      remaining_d = remaining_q - DW'(1);
    end else begin
      remaining_d = remaining_q;
    end

    // Host clear is applied first so a same-cycle set overrides it.
    done_st_d  = done_st_q;
    abort_st_d = abort_st_q;
    if (wr_status_s) begin
      if (bus.Tdata[STAT_DONE_BIT])  done_st_d  = 1'b0;
      else                           done_st_d  = done_st_q;
      if (bus.Tdata[STAT_ABORT_BIT]) abort_st_d = 1'b0;
      else                           abort_st_d = abort_st_q;
    end else begin
      done_st_d  = done_st_q;
      abort_st_d = abort_st_q;
    end
    if (state_q == DONE) done_st_d = 1'b1;
    else                 done_st_d = done_st_d;
    if ((state_q == ACTIVE) && abort_s) abort_st_d = 1'b1;
    else                                abort_st_d = abort_st_d;

    rvalid_d = bus.Tread;
    rdata_d  = rdata_q;
    if (bus.Tread) begin
      case (bus.Taddr)
        AW'(ADDR_SIZE):   rdata_d = size_sh_q;
        AW'(ADDR_BURST):  rdata_d = burst_sh_q;
        AW'(ADDR_STATUS): rdata_d = status_s;
        default:          rdata_d = '0;
      endcase
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Datapath and readback registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_sh_q   <= '0;
      burst_sh_q  <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      remaining_q <= '0;
      done_st_q   <= 1'b0;
      abort_st_q  <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      size_sh_q   <= size_sh_d;
      burst_sh_q  <= burst_sh_d;
      size_q      <= size_d;
      burst_q     <= burst_d;
      remaining_q <= remaining_d;
      done_st_q   <= done_st_d;
      abort_st_q  <= abort_st_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign size_out   = size_q;
  assign burst_out  = burst_q;
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_tx_ctrl_regfile.sv
// Directed self-checking bench for tx_ctrl_regfile: register access, bursts,
// abort, zero-length burst, reset mid-burst and unmapped addresses.
module tb_tx_ctrl_regfile;
  import tx_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          rst;
  logic          byte_done;
  logic [DW-1:0] size_out;
  logic [DW-1:0] burst_out;
  logic          tx_req;
  logic          done_irq;
  int            errors;
  int            checks;

  tx_ctrl_regfile_if #(.DW(DW), .AW(AW)) bus ();

  tx_ctrl_regfile #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .size_out  (size_out),
    .burst_out (burst_out),
    .tx_req    (tx_req),
    .byte_done (byte_done),
    .done_irq  (done_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.Twrite = 1'b1; bus.Taddr = a; bus.Tdata = d;
    tick();
    bus.Twrite = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
    bus.Tread = 1'b1; bus.Taddr = a;
    tick();
    bus.Tread = 1'b0;
    d = bus.rdata; v = bus.rvalid;
  endtask

  task automatic pulse_beat();
    byte_done = 1'b1;
    tick();
    byte_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] d; logic v;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (size_out !== 8'h00) begin errors++; $display("FAIL reset_size got %h exp 00", size_out); end
    checks++; if (burst_out !== 8'h00) begin errors++; $display("FAIL reset_burst got %h exp 00", burst_out); end
    checks++; if ({tx_req, done_irq, bus.rvalid} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {tx_req, done_irq, bus.rvalid}); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.rdata); end
    for (int a = 0; a < 4; a++) begin
      do_read(AW'(a), d, v);
      checks++; if (d !== 8'h00 || v !== 1'b1) begin errors++; $display("FAIL reset_read%0d got %h/%b exp 00/1", a, d, v); end
    end
    tick();
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_drop got %b exp 0", bus.rvalid); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] d; logic v;
    do_write(4'd1, 8'h20);
    do_write(4'd2, 8'h03);
    do_write(4'd0, 8'h01);
    checks++; if (size_out !== 8'h20 || burst_out !== 8'h03) begin errors++; $display("FAIL go_outs got %h/%h exp 20/03", size_out, burst_out); end
    checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL go_txreq got %b exp 1", tx_req); end
    pulse_beat();
    pulse_beat();
    checks++; if (tx_req !== 1'b1 || done_irq !== 1'b0) begin errors++; $display("FAIL beat2 got %b%b exp 10", tx_req, done_irq); end
    pulse_beat();
    checks++; if (done_irq !== 1'b1 || tx_req !== 1'b0) begin errors++; $display("FAIL done_pulse got irq=%b req=%b exp 1/0", done_irq, tx_req); end
    tick();
    checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", done_irq); end
    do_read(4'd3, d, v);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL status_done got %h exp 02", d); end
    do_write(4'd3, 8'h02);
    do_read(4'd3, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL status_clr got %h exp 00", d); end
  endtask

  task automatic test_shadow_and_rego();
    logic [DW-1:0] d; logic v;
    do_write(4'd0, 8'h01);
    pulse_beat();
    do_write(4'd1, 8'h55);
    checks++; if (size_out !== 8'h20) begin errors++; $display("FAIL active_size got %h exp 20", size_out); end
    do_read(4'd1, d, v);
    checks++; if (d !== 8'h55) begin errors++; $display("FAIL shadow_read got %h exp 55", d); end
    do_write(4'd0, 8'h01);
    checks++; if (size_out !== 8'h20) begin errors++; $display("FAIL rego_size got %h exp 20", size_out); end
    pulse_beat();
    checks++; if (tx_req !== 1'b1 || done_irq !== 1'b0) begin errors++; $display("FAIL rego_beat2 got %b%b exp 10", tx_req, done_irq); end
    pulse_beat();
    checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL rego_done got %b exp 1", done_irq); end
    tick();
    // same-cycle read and write of SIZE returns the old value
    bus.Tread = 1'b1; bus.Twrite = 1'b1; bus.Taddr = 4'd1; bus.Tdata = 8'h66;
    tick();
    bus.Tread = 1'b0; bus.Twrite = 1'b0;
    checks++; if (bus.rdata !== 8'h55) begin errors++; $display("FAIL rw_same got %h exp 55", bus.rdata); end
    do_read(4'd1, d, v);
    checks++; if (d !== 8'h66) begin errors++; $display("FAIL rw_after got %h exp 66", d); end
    do_write(4'd3, 8'h06);
  endtask

  task automatic test_zero_burst();
    logic [DW-1:0] d; logic v;
    do_write(4'd2, 8'h00);
    do_write(4'd0, 8'h01);
    checks++; if (tx_req !== 1'b0 || done_irq !== 1'b1) begin errors++; $display("FAIL zero_go got req=%b irq=%b exp 0/1", tx_req, done_irq); end
    do_write(4'd3, 8'h02);
    checks++; if (done_irq !== 1'b0 || tx_req !== 1'b0) begin errors++; $display("FAIL zero_after got req=%b irq=%b exp 0/0", tx_req, done_irq); end
    do_read(4'd3, d, v);
    checks++; if (d !== 8'h02) begin errors++; $display("FAIL set_wins got %h exp 02", d); end
    do_write(4'd3, 8'h02);
  endtask

  task automatic test_abort();
    logic [DW-1:0] d; logic v;
    int irqs;
    do_write(4'd2, 8'h03);
    irqs = 0;
    do_write(4'd0, 8'h01);
    pulse_beat();
    do_write(4'd0, 8'h02);
    checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL abort_mid got req=%b exp 0", tx_req); end
    for (int i = 0; i < 3; i++) begin if (done_irq) irqs++; tick(); end
    do_read(4'd3, d, v);
    checks++; if (d !== 8'h04 || irqs !== 0) begin errors++; $display("FAIL abort_mid_status got %h irqs=%0d exp 04/0", d, irqs); end
    do_write(4'd3, 8'h04);
    do_write(4'd0, 8'h01);
    pulse_beat();
    pulse_beat();
    byte_done = 1'b1; bus.Twrite = 1'b1; bus.Taddr = 4'd0; bus.Tdata = 8'h02;
    tick();
    byte_done = 1'b0; bus.Twrite = 1'b0;
    for (int i = 0; i < 3; i++) begin if (done_irq) irqs++; tick(); end
    do_read(4'd3, d, v);
    checks++; if (d !== 8'h04 || irqs !== 0 || tx_req !== 1'b0) begin errors++; $display("FAIL abort_last got %h irqs=%0d req=%b exp 04/0/0", d, irqs, tx_req); end
    do_write(4'd3, 8'h04);
    do_read(4'd3, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_clr got %h exp 00", d); end
  endtask

  task automatic test_reset_mid_and_unmapped();
    logic [DW-1:0] d; logic v;
    do_write(4'd0, 8'h01);
    pulse_beat();
    bus.Tread = 1'b1; bus.Taddr = 4'd1;
    rst = 1'b1; tick(); rst = 1'b0; bus.Tread = 1'b0;
    checks++; if ({size_out, burst_out} !== 16'h0000 || {tx_req, done_irq, bus.rvalid} !== 3'b000 || bus.rdata !== 8'h00) begin
      errors++; $display("FAIL rst_mid got %h/%h %b%b%b rdata=%h exp all 0", size_out, burst_out, tx_req, done_irq, bus.rvalid, bus.rdata); end
    tick();
    checks++; if (done_irq !== 1'b0 || tx_req !== 1'b0) begin errors++; $display("FAIL rst_mid_after got %b%b exp 00", tx_req, done_irq); end
    do_read(4'd3, d, v);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_status got %h exp 00", d); end
    do_write(4'd1, 8'h11);
    do_write(4'd2, 8'h22);
    do_write(4'd7, 8'hFF);
    do_write(4'd5, 8'hEE);
    do_write(4'd4, 8'h01);
    checks++; if (tx_req !== 1'b0 || size_out !== 8'h00) begin errors++; $display("FAIL unmapped_go got req=%b size=%h exp 0/00", tx_req, size_out); end
    do_read(4'd1, d, v);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL unmapped_size got %h exp 11", d); end
    do_read(4'd2, d, v);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL unmapped_burst got %h exp 22", d); end
    do_read(4'd7, d, v);
    checks++; if (d !== 8'h00 || v !== 1'b1) begin errors++; $display("FAIL unmapped_read got %h/%b exp 00/1", d, v); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; byte_done = 1'b0;
    bus.Twrite = 1'b0; bus.Tread = 1'b0; bus.Taddr = '0; bus.Tdata = '0;
    test_reset();
    test_burst();
    test_shadow_and_rego();
    test_zero_burst();
    test_abort();
    test_reset_mid_and_unmapped();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
